// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, stall vectors and FSM encodings for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int STALL_W    = 6;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;
  localparam logic [DATA_W-1:0]     ZERO_WORD     = '0;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE  = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_FRONT = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_TO_EX = 6'b000111;

  typedef enum logic [1:0] {
    PIPE_RUN        = 2'd0,
    PIPE_LOAD_STALL = 2'd1,
    PIPE_MC_WAIT    = 2'd2,
    PIPE_FLUSH      = 2'd3
  } pipe_state_e;

  // r0 is hard-wired to zero, so reading it never depends on an in-flight load.
  function automatic logic port_hit(input logic                  en,
                                    input logic [REG_ADDR_W-1:0] addr,
                                    input logic [REG_ADDR_W-1:0] wr_addr);
    return en && (addr == wr_addr) && (addr != ZERO_REG_ADDR);
  endfunction

endpackage

// File: rtl/pipe_ctrl_load_use.sv
// load_use_detect: flags an ID read that depends on the register a load in EX is writing.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  reg_read_en_1,
  input  logic [REG_ADDR_W-1:0] reg_addr_1,
  input  logic                  reg_read_en_2,
  input  logic [REG_ADDR_W-1:0] reg_addr_2,
  input  logic                  ex_load,
  input  logic                  ex_write_reg_en,
  input  logic [REG_ADDR_W-1:0] ex_write_reg_addr,
  output logic                  lu_hit
);

  logic hit_1;
  logic hit_2;

  assign hit_1  = port_hit(reg_read_en_1, reg_addr_1, ex_write_reg_addr);
  assign hit_2  = port_hit(reg_read_en_2, reg_addr_2, ex_write_reg_addr);
  assign lu_hit = ex_load & ex_write_reg_en & (hit_1 | hit_2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use bubble, multi-cycle EX freeze with watchdog,
// two-cycle exception flush. Optional ID-stall cycle counter under PIPE_STALL_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_MAX_CYCLES = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_read_en_1,
  input  logic [REG_ADDR_W-1:0] reg_addr_1,
  input  logic                  reg_read_en_2,
  input  logic [REG_ADDR_W-1:0] reg_addr_2,
  input  logic                  ex_load,
  input  logic                  ex_write_reg_en,
  input  logic [REG_ADDR_W-1:0] ex_write_reg_addr,
  input  logic                  ex_mc_start,
  input  logic                  ex_mc_done,
  input  logic                  flush_req,
  output logic [STALL_W-1:0]    stall,
  output logic                  flush,
  output logic                  mc_timeout,
  output logic [DATA_W-1:0]     stall_cycles,
  output pipe_state_e           dbg_state
);

  localparam int CNT_W = $clog2(MC_MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MC_MAX_CYCLES);

  pipe_state_e        state_q, state_d;
  logic [CNT_W-1:0]   mc_cnt_q, mc_cnt_d;
  logic [STALL_W-1:0] stall_c;
  logic               flush_c;
  logic               timeout_c;
  logic               lu_hit;

  load_use_detect u_load_use_detect (
    .reg_read_en_1     (reg_read_en_1),
    .reg_addr_1        (reg_addr_1),
    .reg_read_en_2     (reg_read_en_2),
    .reg_addr_2        (reg_addr_2),
    .ex_load           (ex_load),
    .ex_write_reg_en   (ex_write_reg_en),
    .ex_write_reg_addr (ex_write_reg_addr),
    .lu_hit            (lu_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PIPE_RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mc_cnt_d  = mc_cnt_q;
    stall_c   = STALL_NONE;
    flush_c   = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      PIPE_RUN: begin
        if (flush_req) begin
          flush_c = 1'b1;
          state_d = PIPE_FLUSH;
        end else if (ex_mc_start) begin
          stall_c  = STALL_FRONT;
          mc_cnt_d = CNT_W'(1);
          state_d  = PIPE_MC_WAIT;
        end else if (lu_hit) begin
          stall_c = STALL_TO_EX;
          state_d = PIPE_LOAD_STALL;
        end
      end
      PIPE_LOAD_STALL: begin
        if (flush_req) begin
          flush_c = 1'b1;
          state_d = PIPE_FLUSH;
        end else begin
          state_d = PIPE_RUN;
        end
      end
      PIPE_MC_WAIT: begin
        // The counter never passes CNT_MAX: reaching it forces the exit below.
        if (flush_req) begin
          flush_c  = 1'b1;
          mc_cnt_d = '0;
          state_d  = PIPE_FLUSH;
        end else if (ex_mc_done) begin
          mc_cnt_d = '0;
          state_d  = PIPE_RUN;
        end else if (mc_cnt_q == CNT_MAX) begin
          timeout_c = 1'b1;
          mc_cnt_d  = '0;
          state_d   = PIPE_RUN;
        end else begin
          stall_c  = STALL_FRONT;
          mc_cnt_d = mc_cnt_q + CNT_W'(1);
        end
      end
      PIPE_FLUSH: begin
        flush_c = 1'b1;
        state_d = flush_req ? PIPE_FLUSH : PIPE_RUN;
      end
      default: state_d = PIPE_RUN;
    endcase
  end

  // Outputs are combinational from inputs, so they are masked while reset is held.
  assign stall      = rst ? STALL_NONE : stall_c;
  assign flush      = rst ? 1'b0 : flush_c;
  assign mc_timeout = rst ? 1'b0 : timeout_c;
  assign dbg_state  = state_q;

`ifdef PIPE_STALL_CNT_EN
  logic [DATA_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= ZERO_WORD;
    end else if (stall[STALL_ID]) begin
      stall_cnt_q <= stall_cnt_q + DATA_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = ZERO_WORD;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage CPU. It detects load-use hazards against the ID stage's register read requests and freezes the front end while a multi-cycle EX operation runs. It also sequences the two-cycle flush raised by an exception in MEM. It sits beside ID and drives the stall and flush inputs of every pipeline register.

## Interface

Parameters:
- `MC_MAX_CYCLES`, default 40: watchdog limit, in cycles, for a multi-cycle EX operation.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous reset, active-high (`RST_ENABLE`).
- `reg_read_en_1` in 1: ID read port 1 enable.
- `reg_addr_1` in `REG_ADDR_BUS`: ID read port 1 address.
- `reg_read_en_2` in 1: ID read port 2 enable.
- `reg_addr_2` in `REG_ADDR_BUS`: ID read port 2 address.
- `ex_load` in 1: the EX instruction is a memory load.
- `ex_write_reg_en` in 1: the EX instruction writes a register.
- `ex_write_reg_addr` in `REG_ADDR_BUS`: EX destination register.
- `ex_mc_start` in 1: one-cycle pulse; EX has begun a multi-cycle operation.
- `ex_mc_done` in 1: one-cycle pulse; the multi-cycle result is valid.
- `flush_req` in 1: MEM exception, level-sensitive for one cycle.
- `stall` out `STALL_BUS` (6): per-stage hold; bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- `flush` out 1: clear the IF/ID, ID/EX and EX/MEM registers.
- `mc_timeout` out 1: one-cycle pulse when the watchdog expires.
- `stall_cycles` out `DATA_BUS`: count of ID-stall cycles (see Configuration).

## Operation

- The FSM has four states: `RUN`, `LOAD_STALL`, `MC_WAIT`, `FLUSH`. The reset state is `RUN`.
- Hazard term `lu_hit`:
  - A read port contributes when its enable is high, its address equals `ex_write_reg_addr`, and its address is not `ZERO_REG_ADDR`.
  - `lu_hit` is `ex_load & ex_write_reg_en & (port1 | port2)`.
- Priority is `flush_req` > `ex_mc_start` / `MC_WAIT` > `lu_hit`.
- `RUN`:
  - On `flush_req`, drive `flush=1` and `stall=0`, then go to `FLUSH`.
  - Otherwise, on `ex_mc_start`, drive `stall=6'b001111` and go to `MC_WAIT`. The watchdog counter loads 1.
  - Otherwise, on `lu_hit`, drive `stall=6'b000111` (EX receives a bubble) and go to `LOAD_STALL`.
  - Otherwise drive `stall=0` and stay in `RUN`.
- `LOAD_STALL`:
  - Lasts exactly one cycle with `stall=0`; the loaded value is now forwardable from MEM.
  - Next state is `RUN`.
  - A `flush_req` in this cycle goes to `FLUSH` instead.
- `MC_WAIT`:
  - Drives `stall=6'b001111`; the counter increments each cycle and saturates at `MC_MAX_CYCLES`.
  - On `ex_mc_done`, drive `stall=0` in that cycle and go to `RUN`.
  - If the counter equals `MC_MAX_CYCLES` without `ex_mc_done`, pulse `mc_timeout`, drive `stall=0`, and go to `RUN`.
  - On `flush_req`, go to `FLUSH`; this overrides both done and timeout. The counter clears.
- `FLUSH`:
  - Drives `flush=1` and `stall=0` for one cycle; next state is `RUN`.
  - A new `flush_req` here extends `FLUSH` by one cycle.
  - `ex_mc_start` and `lu_hit` are ignored in this state.
- `ex_mc_start` while already in `MC_WAIT` is ignored.
- `ex_mc_done` outside `MC_WAIT` is ignored.
- Reset mid-operation: state returns to `RUN` and the counter to 0 immediately. Outputs go to `stall=0`, `flush=0`, `mc_timeout=0`, `stall_cycles=ZERO_WORD`.
- While `rst` is active, all outputs hold their reset values regardless of inputs.

## Timing

- `stall` and `flush` are combinational from the current state and inputs. The state register updates on the following edge.
- Load-use costs exactly one bubble: hazard seen in cycle N, the dependent instruction leaves ID in cycle N+1.
- A multi-cycle op with `ex_mc_done` K cycles after start (K ≥ 1) holds the front end for K cycles. The PC advances in the cycle `ex_mc_done` is high.
- A flush is high for two consecutive cycles: the `flush_req` cycle plus the `FLUSH` cycle.
- `mc_timeout` is high exactly in cycle `MC_MAX_CYCLES` after `ex_mc_start`.

## Configuration

- `PIPE_STALL_CNT_EN` defined:
  - `stall_cycles` is a 32-bit register that increments on each cycle with `stall[2]=1`.
  - It wraps from `32'hFFFFFFFF` to 0 and clears on reset.
- `PIPE_STALL_CNT_EN` undefined:
  - `stall_cycles` is tied to `ZERO_WORD`; no counter is synthesized.

## Structure

- Add to `define/global_def.v`: `STALL_BUS` (5:0) and stall bit positions (`STALL_PC`…`STALL_WB`).
- Add to `define/global_def.v`: FSM encodings `PIPE_RUN`, `PIPE_LOAD_STALL`, `PIPE_MC_WAIT`, `PIPE_FLUSH` (2 bits), plus `STALL_NONE` / `STALL_FRONT` / `STALL_TO_EX` vector constants.
- One sub-module, `load_use_detect`: combinational `lu_hit` from the two ID read ports and the EX write info.

## Test plan

- ID reads r3 on port 1 while EX does `lw` to r3 → one cycle with `stall=000111`, then 0. The dependent instruction issues one cycle later.
- Same as above but the target is r0, or `reg_read_en_1=0` → `stall` stays 0.
- `ex_mc_start`, then `ex_mc_done` 5 cycles later → `stall=001111` for 5 cycles, 0 in the done cycle. With `PIPE_STALL_CNT_EN`, `stall_cycles` rises by 5.
- `ex_mc_start` with no done and `MC_MAX_CYCLES=40` → `mc_timeout` pulses in cycle 40, then `RUN` with `stall=0`.
- `flush_req` in the same cycle as `lu_hit` and `ex_mc_start` → `flush=1` for 2 cycles, `stall=0` throughout, then `RUN`.
- Assert `rst` during the 3rd cycle of `MC_WAIT` → all outputs 0 immediately. After release, a fresh `ex_mc_start` times out at the full `MC_MAX_CYCLES`.
